mbm_mul_sched: RTL and testbench
================================

# mbm_mul_sched

Shares one combinational 8×8 approximate logarithmic multiplier core among `NUM_REQ` independent requesters.
- Round-robin arbitration picks one request per cycle.
- Operands and results are registered around the core in a 2-stage pipeline.
- Each result returns on a single tagged response channel with valid/ready backpressure.
- The block sits between the multiply-issuing datapaths and the multiplier core. It is the only path by which those datapaths reach the core.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: width of the requester tag.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_a` in `NUM_REQ*8`: packed operand A; requester i uses bits [8i+7:8i].
- `req_b` in `NUM_REQ*8`: packed operand B, same packing as `req_a`.
- `req_ready` out `NUM_REQ`: per-requester accept; at most one bit high.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: downstream accepts result.
- `rsp_id` out `ID_W`: index of the requester that issued this result.
- `rsp_product` out 16: approximate product.
- `done_cnt` out 16: count of completed responses, wraps modulo 2^16.

## Operation
- **Arbitration**
  - A round-robin pointer `rr_ptr` (`ID_W` bits) gives highest priority to requester `rr_ptr`, then `rr_ptr`+1, and so on, modulo `NUM_REQ`.
  - `grant` is the one-hot winner among the asserted `req_valid` bits.
  - `req_ready[i]` = `grant[i]` AND `s1_load`. It is combinational from `req_valid`.
  - A request is accepted when `req_valid[i]` and `req_ready[i]` are both high on a clock edge.
  - On accept, `rr_ptr` becomes (i+1) mod `NUM_REQ`. With no accept, `rr_ptr` holds.
- **Stage 1 (operand register)**
  - Holds `s1_valid`, `s1_a`, `s1_b`, `s1_id`.
  - `s1_load` = !`s1_valid` OR `s2_load`.
  - When `s1_load` is high: `s1_valid` takes "any grant" and the granted operands are captured.
- **Core**
  - The multiplier core is purely combinational on `s1_a`/`s1_b`.
  - Zero rule: if `s1_a`==0 or `s1_b`==0, the product is forced to 16'h0000. The core's log-domain output is invalid for zero operands.
- **Stage 2 (result register)**
  - Holds `s2_valid`, `s2_product`, `s2_id`.
  - `s2_load` = !`s2_valid` OR `rsp_ready`.
  - When `s2_load` is high, stage 2 takes stage 1's contents, including `s1_valid`.
- **Outputs**
  - `rsp_valid`/`rsp_id`/`rsp_product` are driven directly from the stage-2 registers.
  - Handshake: while `rsp_valid`=1 and `rsp_ready`=0, `rsp_id` and `rsp_product` hold stable.
  - `done_cnt` increments on every `rsp_valid` AND `rsp_ready` edge.
- **Ordering:** responses leave in acceptance order. No reordering and no drop.

## Timing
- Reset (asynchronous assert, synchronous release): all valids 0, `rr_ptr`=0, `rsp_product`=0, `rsp_id`=0, `done_cnt`=0, `req_ready`=0.
- Latency: a request accepted at edge k presents `rsp_valid`=1 after edge k+1. The response handshake can complete at edge k+2.
- Throughput: one accept per cycle while `rsp_ready` is held high. The pipeline holds at most 2 outstanding operations.
- Backpressure: with `rsp_ready`=0 and both stages full, all `req_ready`=0 and `rr_ptr` holds. When `rsp_ready` rises, accepts resume in the same cycle, because `s2_load` feeds `s1_load` combinationally.
- A requester may drop `req_valid` before acceptance; no state is affected.
- Simultaneous requests are granted one per cycle in rotating order. Each of the `NUM_REQ` requesters is served within `NUM_REQ` accepts.
- Reset asserted mid-operation discards in-flight operations. No response is issued for them, and `done_cnt` returns to 0.

## Structure
- Shared package `mbm_pkg`:
  - `MBM_OP_W`=8 and `MBM_PROD_W`=16.
  - Function `mbm_zero_guard(a, b, p)` implementing the zero rule.
- Sub-module `mbm_rr_arbiter` (parameter `NUM_REQ`). It contains the pointer register and the one-hot grant logic, with inputs `req`, `advance` and output `grant`.
- The existing combinational multiplier core is instantiated once, unmodified, between stage 1 and stage 2.
- Top-level: pipeline registers, handshake logic, `done_cnt`.

## Test plan
- **Single request:** after reset, req 2 with a=8'd0, b=8'd77, `rsp_ready`=1.
  - `req_ready[2]` is high in the same cycle.
  - `rsp_valid` follows one edge after accept, with `rsp_id`=2 and `rsp_product`=16'h0000.
  - `done_cnt` reads 1 after the response handshake.
- **All requesters at once, held:** `NUM_REQ`=4, `rsp_ready`=1.
  - Grants go 0,1,2,3,0,… on consecutive cycles, and `rsp_id` follows the same sequence.
  - Each nonzero product (e.g. a=8'd200, b=8'd13) equals the golden model: zero guard applied to the core output.
- **Backpressure:** fill both stages, then hold `rsp_ready`=0 for 5 cycles.
  - `req_ready` is all 0 throughout, and `rsp_id`/`rsp_product` are stable.
  - On release, exactly 2 responses drain in order and no request is lost.
- **Fairness:** hold requester 0 continuously and pulse requester 3.
  - Requester 3 is granted within 2 accepts of raising `req_valid`.
- **Reset mid-flight:** assert `rst_n`=0 with 2 operations outstanding.
  - `rsp_valid` goes to 0 immediately.
  - After release, no stale response appears, and `done_cnt`=0 and `rr_ptr`=0.
- **Counter wrap:** preload traffic for 65536 responses.
  - `done_cnt` returns to 16'h0000 on the 65536th handshake.

Source files
------------

// File: rtl/mbm_pkg.sv
// Shared definitions for the shared multiplier scheduler.
// Contents: operand/product widths and the zero-operand guard applied to the
// approximate (logarithmic) multiplier output.
package mbm_pkg;

    localparam int MBM_OP_W   = 8;
    localparam int MBM_PROD_W = 16;

    // The log-domain core has no representation for zero, so any zero operand
    // must force the product to zero regardless of what the core produced.
    function automatic logic [MBM_PROD_W-1:0] mbm_zero_guard(
        input logic [MBM_OP_W-1:0]   a,
        input logic [MBM_OP_W-1:0]   b,
        input logic [MBM_PROD_W-1:0] p
    );
        logic [MBM_PROD_W-1:0] r;
        if ((a == {MBM_OP_W{1'b0}}) || (b == {MBM_OP_W{1'b0}})) begin
            r = {MBM_PROD_W{1'b0}};
        end else begin
            r = p;
        end
        return r;
    endfunction

endpackage

// File: rtl/mbm_log_mul_core.sv
// Combinational 8x8 approximate logarithmic (Mitchell) multiplier core.
// Ports: a, b (8-bit operands) -> p (16-bit approximate product).
// Output is meaningless when either operand is zero; callers must guard it.
module mbm_log_mul_core (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    // Position of the leading one (characteristic of log2).
    function automatic logic [2:0] lod(input logic [7:0] x);
        logic [2:0] pos;
        pos = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) begin
                pos = 3'(i);
            end else begin
                pos = pos;
            end
        end
        return pos;
    endfunction

    logic [2:0]  ka_s;
    logic [2:0]  kb_s;
    logic [7:0]  a_norm_s;
    logic [7:0]  b_norm_s;
    logic [7:0]  fsum_s;
    logic [3:0]  k_s;
    logic [15:0] mant_s;

    // Log-add-antilog datapath.
    always_comb begin
        ka_s     = lod(a);
        kb_s     = lod(b);
        // Normalise so the leading one sits in bit 7; bits [6:0] are the fraction.
        a_norm_s = a << (3'd7 - ka_s);
        b_norm_s = b << (3'd7 - kb_s);
        // Both normalised values carry an implicit 128; the modulo-256 sum
        // therefore equals the plain sum of the two 7-bit fractions.
        fsum_s   = a_norm_s + b_norm_s;
        k_s      = {1'b0, ka_s} + {1'b0, kb_s} + {3'd0, fsum_s[7]};
        mant_s   = {8'd0, 1'b1, fsum_s[6:0]};
        // Result is mant * 2^(k-7); the low bits shifted out are always zero.
        if (k_s >= 4'd7) begin
            p = mant_s << (k_s - 4'd7);
        end else begin
            p = mant_s >> (4'd7 - k_s);
        end
    end

endmodule

// File: rtl/mbm_rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
// Ports: clk, rst_n; req (per-requester request), advance (an accept can
// happen this cycle); grant (one-hot winner), grant_id (its index),
// grant_any (some requester wins).
module mbm_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               grant_any
);

    logic [ID_W-1:0] rr_ptr_r;

    // Search from rr_ptr upward (wrapping) for the first asserted request.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = {NUM_REQ{1'b0}};
        grant_id  = {ID_W{1'b0}};
        grant_any = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = (int'(rr_ptr_r) + off) % NUM_REQ;
            if (!grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                grant_any  = 1'b1;
            end else begin
                grant_any  = grant_any;
            end
        end
    end

    // Pointer moves just past the winner on an accept, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= {ID_W{1'b0}};
        end else if (advance && grant_any) begin
            if (grant_id == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_r <= {ID_W{1'b0}};
            end else begin
                rr_ptr_r <= grant_id + ID_W'(1);
            end
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: rtl/mbm_mul_sched.sv
// Shares one approximate multiplier core among NUM_REQ requesters.
// Round-robin accept -> stage 1 (operands) -> core -> stage 2 (result) ->
// single tagged valid/ready response channel.
// Ports: clk, rst_n; req_valid/req_a/req_b in, req_ready out (per requester);
// rsp_valid, rsp_id, rsp_product out, rsp_ready in; done_cnt (completed
// responses, wrapping).
module mbm_mul_sched
    import mbm_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*8-1:0]  req_a,
    input  logic [NUM_REQ*8-1:0]  req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [15:0]           rsp_product,
    output logic [15:0]           done_cnt
);

    logic [NUM_REQ-1:0]    grant_s;
    logic [ID_W-1:0]       grant_id_s;
    logic                  grant_any_s;
    logic                  s1_load_s;
    logic                  s2_load_s;
    logic [MBM_OP_W-1:0]   sel_a_s;
    logic [MBM_OP_W-1:0]   sel_b_s;
    logic [MBM_PROD_W-1:0] core_p_s;

    logic                  s1_valid_r;
    logic [MBM_OP_W-1:0]   s1_a_r;
    logic [MBM_OP_W-1:0]   s1_b_r;
    logic [ID_W-1:0]       s1_id_r;
    logic                  s2_valid_r;
    logic [MBM_PROD_W-1:0] s2_product_r;
    logic [ID_W-1:0]       s2_id_r;
    logic [15:0]           done_cnt_r;

    // A stage can load when it is empty or the stage after it is moving;
    // the chain is combinational so a released rsp_ready reopens intake at once.
    assign s2_load_s = !s2_valid_r || rsp_ready;
    assign s1_load_s = !s1_valid_r || s2_load_s;
    assign req_ready = grant_s & {NUM_REQ{s1_load_s}};

    mbm_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .advance   (s1_load_s),
        .grant     (grant_s),
        .grant_id  (grant_id_s),
        .grant_any (grant_any_s)
    );

    // One-hot AND-OR mux of the granted requester's operands.
    always_comb begin
        sel_a_s = {MBM_OP_W{1'b0}};
        sel_b_s = {MBM_OP_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_a_s = sel_a_s | (req_a[i*8 +: 8] & {MBM_OP_W{grant_s[i]}});
            sel_b_s = sel_b_s | (req_b[i*8 +: 8] & {MBM_OP_W{grant_s[i]}});
        end
    end

    // Stage 1: operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {MBM_OP_W{1'b0}};
            s1_b_r     <= {MBM_OP_W{1'b0}};
            s1_id_r    <= {ID_W{1'b0}};
        end else if (s1_load_s) begin
            s1_valid_r <= grant_any_s;
            s1_a_r     <= sel_a_s;
            s1_b_r     <= sel_b_s;
            s1_id_r    <= grant_id_s;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    mbm_log_mul_core u_core (
        .a (s1_a_r),
        .b (s1_b_r),
        .p (core_p_s)
    );

    // Stage 2: result register; holds steady while the response is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r   <= 1'b0;
            s2_product_r <= {MBM_PROD_W{1'b0}};
            s2_id_r      <= {ID_W{1'b0}};
        end else if (s2_load_s) begin
            s2_valid_r   <= s1_valid_r;
            s2_product_r <= mbm_zero_guard(s1_a_r, s1_b_r, core_p_s);
            s2_id_r      <= s1_id_r;
        end else begin
            s2_valid_r   <= s2_valid_r;
        end
    end

    // Completed-response counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_r <= 16'd0;
        end else if (s2_valid_r && rsp_ready) begin
            done_cnt_r <= done_cnt_r + 16'd1;
        end else begin
            done_cnt_r <= done_cnt_r;
        end
    end

    assign rsp_valid   = s2_valid_r;
    assign rsp_id      = s2_id_r;
    assign rsp_product = s2_product_r;
    assign done_cnt    = done_cnt_r;

endmodule

// File: tb/tb_mbm_mul_sched.sv
// Directed self-checking bench for mbm_mul_sched (NUM_REQ = 4).
module tb_mbm_mul_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [15:0]          rsp_product;
    logic [15:0]          done_cnt;

    typedef struct {
        int id;
        int prod;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_errors;
    int   exp_done;
    int   hs_cnt;

    mbm_mul_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_product (rsp_product),
        .done_cnt    (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Mitchell product written as exact integers:
    // a = 2^ka + da, b = 2^kb + db, t = da*2^kb + db*2^ka.
    // If the fractions sum below one: 2^(ka+kb) + t, otherwise 2*t.
    function automatic int model(input int a, input int b);
        int ka, kb, base, t;
        if (a == 0 || b == 0) return 0;
        ka = 0;
        kb = 0;
        while ((a >> (ka + 1)) != 0) ka++;
        while ((b >> (kb + 1)) != 0) kb++;
        base = 1 << (ka + kb);
        t = (a - (1 << ka)) * (1 << kb) + (b - (1 << kb)) * (1 << ka);
        if (t < base) return base + t;
        return 2 * t;
    endfunction

    // Observe the handshakes that are about to complete on the next edge.
    task automatic monitor();
        exp_t e;
        check_val("rdy_onehot", ($countones(req_ready) <= 1) ? 32'd1 : 32'd0, 32'd1);
        if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check_val("rsp_spurious", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_val("rsp_id", 32'(rsp_id), e.id);
                check_val("rsp_prod", 32'(rsp_product), e.prod);
            end
            hs_cnt++;
            exp_done++;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                e.id   = i;
                e.prod = model(int'(req_a[i*8 +: 8]), int'(req_b[i*8 +: 8]));
                sb_q.push_back(e);
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        sb_q.delete();
        exp_done  = 0;
        hs_cnt    = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 10 && sb_q.size() != 0; c++) cycle();
        check_val("drain_empty", sb_q.size(), 32'd0);
        check_val("done_cnt", 32'(done_cnt), exp_done & 32'hFFFF);
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        req_a[i*8 +: 8] = 8'(a);
        req_b[i*8 +: 8] = 8'(b);
    endtask

    initial begin
        int hand_p[4];
        int hs0;
        int seen3;
        n_checks = 0;
        n_errors = 0;

        // Reset state while held in reset
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;
        exp_done  = 0;
        hs_cnt    = 0;
        #1;
        check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_val("rst_rsp_prod", 32'(rsp_product), 32'd0);
        check_val("rst_done", 32'(done_cnt), 32'd0);
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_rr_ptr", 32'(dut.u_arb.rr_ptr_r), 32'd0);
        do_reset();

        // Single request, zero operand
        req_valid = 4'b0100;
        set_ops(2, 0, 77);
        rsp_ready = 1'b1;
        #1;
        check_val("single_rdy", 32'(req_ready), 32'b0100);
        cycle();
        req_valid = '0;
        #1;
        check_val("single_lat0", 32'(rsp_valid), 32'd0);
        cycle();
        check_val("single_valid", 32'(rsp_valid), 32'd1);
        check_val("single_id", 32'(rsp_id), 32'd2);
        check_val("single_prod", 32'(rsp_product), 32'd0);
        cycle();
        check_val("single_done", 32'(done_cnt), 32'd1);
        check_val("single_idle", 32'(rsp_valid), 32'd0);
        check_val("single_rr_ptr", 32'(dut.u_arb.rr_ptr_r), 32'd3);

        // All requesters held; hand-computed Mitchell products
        do_reset();
        set_ops(0, 200, 13);  hand_p[0] = 2432;
        set_ops(1, 255, 255); hand_p[1] = 65024;
        set_ops(2, 3, 5);     hand_p[2] = 14;
        set_ops(3, 16, 9);    hand_p[3] = 144;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            #1;
            check_val("rr_grant", 32'(req_ready), 32'(1) << (c % 4));
            if (c >= 2) begin
                check_val("rr_rsp_valid", 32'(rsp_valid), 32'd1);
                check_val("rr_rsp_id", 32'(rsp_id), (c - 2) % 4);
                check_val("rr_hand_prod", 32'(rsp_product), hand_p[(c - 2) % 4]);
            end
            cycle();
        end
        drain();

        // Backpressure with both stages full
        do_reset();
        set_ops(0, 10, 20);
        set_ops(1, 37, 91);
        set_ops(2, 128, 2);
        set_ops(3, 99, 1);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        cycle();
        cycle();
        for (int c = 0; c < 5; c++) begin
            #1;
            check_val("bp_ready", 32'(req_ready), 32'd0);
            check_val("bp_valid", 32'(rsp_valid), 32'd1);
            check_val("bp_id", 32'(rsp_id), sb_q[0].id);
            check_val("bp_prod", 32'(rsp_product), sb_q[0].prod);
            cycle();
        end
        check_val("bp_rr_ptr", 32'(dut.u_arb.rr_ptr_r), 32'd2);
        hs0 = hs_cnt;
        drain();
        check_val("bp_drain_cnt", hs_cnt - hs0, 32'd2);

        // Fairness: requester 0 held, requester 3 pulsed
        do_reset();
        set_ops(0, 5, 6);
        set_ops(3, 9, 10);
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        repeat (3) cycle();
        req_valid = 4'b1001;
        seen3 = 0;
        for (int k = 0; k < 2 && seen3 == 0; k++) begin
            #1;
            if (req_ready[3]) seen3 = 1;
            cycle();
        end
        check_val("fair_r3_granted", seen3, 32'd1);
        req_valid = 4'b0001;
        repeat (2) cycle();
        drain();

        // Reset while two operations are outstanding
        do_reset();
        set_ops(0, 7, 7);
        set_ops(1, 8, 8);
        rsp_ready = 1'b0;
        req_valid = 4'b0011;
        cycle();
        cycle();
        req_valid = '0;
        #1;
        check_val("mid_pre_valid", 32'(rsp_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(rsp_valid), 32'd0);
        sb_q.delete();
        exp_done = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_val("mid_no_stale", 32'(rsp_valid), 32'd0);
            cycle();
        end
        check_val("mid_done", 32'(done_cnt), 32'd0);
        check_val("mid_rr_ptr", 32'(dut.u_arb.rr_ptr_r), 32'd0);

        // Counter wrap after 65536 handshakes
        do_reset();
        set_ops(0, 3, 4);
        set_ops(1, 250, 17);
        set_ops(2, 1, 255);
        set_ops(3, 64, 64);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 70000 && hs_cnt < 65535; c++) cycle();
        check_val("wrap_pre_hs", hs_cnt, 32'd65535);
        check_val("wrap_pre_done", 32'(done_cnt), 32'hFFFF);
        cycle();
        check_val("wrap_hs", hs_cnt, 32'd65536);
        check_val("wrap_done", 32'(done_cnt), 32'd0);
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
